// File: rtl/fire5_pkg.sv
// Shared sizing defaults and FSM encoding for the fire5 expand-3x3 write-back path.
package fire5_pkg;

    localparam int FIRE5_DSP_NO   = 128;
    localparam int FIRE5_WIDTH    = 16;
    localparam int FIRE5_N_PIX    = 1024;
    localparam int FIRE5_CH_TOTAL = 256;
    localparam int FIRE5_CH_BASE  = 128;
    localparam int FIRE5_ADDR_W   = $clog2(FIRE5_N_PIX * FIRE5_CH_TOTAL);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } fire5_state_e;

endpackage

// File: rtl/fire5_ex_3_wb_vec_pingpong.sv
// Two-bank vector buffer: captures whole vectors into a free bank and serves single
// words from the bank being drained. Full flags are the only reset state.
module vec_pingpong #(
    parameter int DSP_NO = 128,
    parameter int WIDTH  = 16,
    parameter int CH_W   = $clog2(DSP_NO)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear_i,
    input  logic                         wrEn_i,
    input  logic [DSP_NO-1:0][WIDTH-1:0] wrData_i,
    input  logic                         relEn_i,
    input  logic                         relBank_i,
    input  logic                         rdBank_i,
    input  logic [CH_W-1:0]              rdCh_i,
    output logic                         accept_o,
    output logic                         wrBank_o,
    output logic [1:0]                   full_o,
    output logic [WIDTH-1:0]             rdWord_o
);

    logic [1:0]                   full_q;
    logic [1:0]                   full_d;
    logic [1:0]                   freeNow;
    logic [DSP_NO-1:0][WIDTH-1:0] bank_q [2];

    // A bank whose last word is being written this cycle already counts as free.
    always_comb begin
        freeNow = ~full_q;
        if (relEn_i) begin
            freeNow[relBank_i] = 1'b1;
        end
    end

    assign accept_o = wrEn_i & (|freeNow);
    assign wrBank_o = ~freeNow[0];

    always_comb begin
        full_d = full_q;
        if (relEn_i) begin
            full_d[relBank_i] = 1'b0;
        end
        if (accept_o) begin
            full_d[wrBank_o] = 1'b1;
        end
        if (clear_i) begin
            full_d = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q <= 2'b00;
        end else begin
            full_q <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept_o) begin
            bank_q[wrBank_o] <= wrData_i;
        end
    end

    assign rdWord_o = bank_q[rdBank_i][rdCh_i];
    assign full_o   = full_q;

endmodule

// File: rtl/fire5_ex_3_wb.sv
// Writes ReLU'd expand-3x3 vectors into the concatenated fire5 output RAM, one channel
// per cycle, at pix*CH_TOTAL + CH_BASE + ch. Two-bank buffering absorbs back-to-back vectors.
module fire5_ex_3_wb
    import fire5_pkg::*;
#(
    parameter int DSP_NO   = FIRE5_DSP_NO,
    parameter int WIDTH    = FIRE5_WIDTH,
    parameter int N_PIX    = FIRE5_N_PIX,
    parameter int CH_TOTAL = FIRE5_CH_TOTAL,
    parameter int CH_BASE  = FIRE5_CH_BASE
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 in_valid,
    input  logic [DSP_NO-1:0][WIDTH-1:0]         vec_in,
    output logic                                 mem_we,
    output logic [$clog2(N_PIX*CH_TOTAL)-1:0]    mem_addr,
    output logic [WIDTH-1:0]                     mem_wdata,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 overflow
);

    localparam int ADDR_W = $clog2(N_PIX * CH_TOTAL);
    localparam int CH_W   = $clog2(DSP_NO);
    localparam int PIX_W  = $clog2(N_PIX);

    fire5_state_e      state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic              rdBank_q, rdBank_d;
    logic              lastWord_q, lastWord_d;
    logic              lastBank_q, lastBank_d;
    logic              memWe_q, memWe_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [WIDTH-1:0]  memWdata_q, memWdata_d;
    logic              done_q, done_d;
    logic              overflow_q, overflow_d;

    logic              wrEn;
    logic              bufClear;
    logic              accept;
    logic              wrBank;
    logic [1:0]        full;
    logic [WIDTH-1:0]  rdWord;
    logic              lastCh;
    logic              lastPix;

    function automatic logic [ADDR_W-1:0] calcAddr(input logic [PIX_W-1:0] pix,
                                                   input logic [CH_W-1:0]  ch);
        return ADDR_W'(pix) * ADDR_W'(CH_TOTAL) + ADDR_W'(CH_BASE) + ADDR_W'(ch);
    endfunction

    vec_pingpong #(
        .DSP_NO (DSP_NO),
        .WIDTH  (WIDTH),
        .CH_W   (CH_W)
    ) uBuf (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (bufClear),
        .wrEn_i    (wrEn),
        .wrData_i  (vec_in),
        .relEn_i   (lastWord_q),
        .relBank_i (lastBank_q),
        .rdBank_i  (rdBank_q),
        .rdCh_i    (ch_q),
        .accept_o  (accept),
        .wrBank_o  (wrBank),
        .full_o    (full),
        .rdWord_o  (rdWord)
    );

    assign lastCh  = (ch_q == CH_W'(DSP_NO - 1));
    assign lastPix = (pix_q == PIX_W'(N_PIX - 1));

    // The bank is released one cycle after its last word is read, i.e. while that word
    // sits on mem_we; the idle path forwards channel 0 straight from vec_in.
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        pix_d      = pix_q;
        rdBank_d   = rdBank_q;
        lastWord_d = 1'b0;
        lastBank_d = lastBank_q;
        memWe_d    = 1'b0;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        done_d     = done_q;
        overflow_d = overflow_q;
        wrEn       = 1'b0;
        bufClear   = 1'b0;

        if (start) begin
            state_d    = IDLE;
            ch_d       = '0;
            pix_d      = '0;
            done_d     = 1'b0;
            overflow_d = 1'b0;
            bufClear   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    wrEn = in_valid;
                    if (accept) begin
                        state_d    = DRAIN;
                        rdBank_d   = wrBank;
                        memWe_d    = 1'b1;
                        memAddr_d  = calcAddr(pix_q, CH_W'(0));
                        memWdata_d = vec_in[0];
                        ch_d       = CH_W'(1);
                    end
                end
                DRAIN: begin
                    memWe_d    = 1'b1;
                    memAddr_d  = calcAddr(pix_q, ch_q);
                    memWdata_d = rdWord;
                    if (!(lastCh && lastPix)) begin
                        wrEn       = in_valid;
                        overflow_d = overflow_q | (in_valid & ~accept);
                    end
                    if (lastCh) begin
                        lastWord_d = 1'b1;
                        lastBank_d = rdBank_q;
                        ch_d       = '0;
                        pix_d      = pix_q + 1'b1;
                        if (lastPix) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else if (full[~rdBank_q]) begin
                            rdBank_d = ~rdBank_q;
                        end else if (accept) begin
                            rdBank_d = wrBank;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        ch_d = ch_q + 1'b1;
                    end
                end
                DONE: begin
                    bufClear = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            pix_q      <= '0;
            rdBank_q   <= 1'b0;
            lastWord_q <= 1'b0;
            lastBank_q <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            pix_q      <= pix_d;
            rdBank_q   <= rdBank_d;
            lastWord_q <= lastWord_d;
            lastBank_q <= lastBank_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    assign mem_we    = memWe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;
    assign busy      = |full;
    assign done      = done_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_fire5_ex_3_wb.sv
// Scoreboard bench for fire5_ex_3_wb: each accepted vector queues its expected RAM writes,
// and a negedge monitor pops and compares them as mem_we fires.
module tb_fire5_ex_3_wb;

    localparam int DSP_NO    = 128;
    localparam int WIDTH     = 16;
    localparam int N_PIX     = 32;
    localparam int CH_TOTAL  = 256;
    localparam int CH_BASE   = 128;
    localparam int ADDR_W    = $clog2(N_PIX * CH_TOTAL);
    localparam int LAST_ADDR = N_PIX * CH_TOTAL - 1;

    logic                         clk = 1'b0;
    logic                         rst = 1'b1;
    logic                         start = 1'b0;
    logic                         in_valid = 1'b0;
    logic [DSP_NO-1:0][WIDTH-1:0] vec_in = '0;
    logic                         mem_we;
    logic [ADDR_W-1:0]            mem_addr;
    logic [WIDTH-1:0]             mem_wdata;
    logic                         busy;
    logic                         done;
    logic                         overflow;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t sbQ[$];
    int   testCount = 0;
    int   failCount = 0;
    int   cyc = 0;
    int   modelPix = 0;
    int   lastIvCyc = 0;
    bit   monEn = 1'b0;
    int   wrCount = 0;
    int   firstCyc = 0;
    int   lastCyc = 0;
    int   spurious = 0;
    bit   doneArm = 1'b0;
    logic doneSeen = 1'b0;
    int   lastAddrSeen = 0;

    fire5_ex_3_wb #(
        .DSP_NO   (DSP_NO),
        .WIDTH    (WIDTH),
        .N_PIX    (N_PIX),
        .CH_TOTAL (CH_TOTAL),
        .CH_BASE  (CH_BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .vec_in    (vec_in),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (doneArm) begin
            doneSeen = done;
            doneArm  = 1'b0;
        end
        if (monEn && mem_we === 1'b1) begin
            if (sbQ.size() == 0) begin
                spurious++;
            end else begin
                e = sbQ.pop_front();
                checkOutput("wr_addr", 32'(mem_addr), e.addr);
                checkOutput("wr_data", 32'(mem_wdata), e.data);
                if (wrCount == 0) firstCyc = cyc;
                lastCyc      = cyc;
                lastAddrSeen = int'(mem_addr);
                wrCount++;
                if (e.addr == 32'(LAST_ADDR)) doneArm = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int seed, input bit expAccept);
        logic [WIDTH-1:0] d;
        for (int i = 0; i < DSP_NO; i++) begin
            d = WIDTH'((seed << 8) + i + 1);
            vec_in[i] = d;
            if (expAccept) begin
                sbQ.push_back(exp_t'{addr: 32'(modelPix * CH_TOTAL + CH_BASE + i), data: 32'(d)});
            end
        end
        if (expAccept) modelPix++;
        in_valid  = 1'b1;
        lastIvCyc = cyc;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic doStart();
        start = 1'b1;
        tick();
        start    = 1'b0;
        modelPix = 0;
        wrCount  = 0;
        spurious = 0;
        sbQ.delete();
    endtask

    task automatic waitIdle(input int maxCyc);
        int n = 0;
        while (sbQ.size() != 0 && n < maxCyc) begin
            tick();
            n++;
        end
        checkOutput("drain_pending", 32'(sbQ.size()), 32'd0);
        repeat (5) tick();
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_we"},   32'(mem_we),    32'd0);
        checkOutput({tag, "_addr"}, 32'(mem_addr),  32'd0);
        checkOutput({tag, "_data"}, 32'(mem_wdata), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy),      32'd0);
        checkOutput({tag, "_done"}, 32'(done),      32'd0);
        checkOutput({tag, "_ovf"},  32'(overflow),  32'd0);
    endtask

    initial begin
        #1_000_000;
        failCount++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        #3 rst = 1'b0;
        #1;
        checkResetOutputs("reset");
        tick();
        tick();
        rst = 1'b1;
        tick();
        monEn = 1'b1;

        // Single vector: channel 0 lands the cycle after capture, channel 127 127 cycles later.
        doStart();
        applyStimulus(0, 1'b1);
        k = lastIvCyc;
        checkOutput("single_busy_during", 32'(busy), 32'd1);
        waitIdle(400);
        checkOutput("single_count", 32'(wrCount), 32'd128);
        checkOutput("single_first_cyc", 32'(firstCyc), 32'(k + 1));
        checkOutput("single_last_cyc", 32'(lastCyc), 32'(k + 128));
        checkOutput("single_busy_after", 32'(busy), 32'd0);
        checkOutput("single_spurious", 32'(spurious), 32'd0);

        // Two vectors two cycles apart drain back to back.
        doStart();
        applyStimulus(1, 1'b1);
        k = lastIvCyc;
        tick();
        applyStimulus(2, 1'b1);
        waitIdle(600);
        checkOutput("pair_count", 32'(wrCount), 32'd256);
        checkOutput("pair_first_cyc", 32'(firstCyc), 32'(k + 1));
        checkOutput("pair_span", 32'(lastCyc - firstCyc), 32'd255);
        checkOutput("pair_overflow", 32'(overflow), 32'd0);
        checkOutput("pair_spurious", 32'(spurious), 32'd0);

        // Third vector while both banks are full is dropped.
        doStart();
        applyStimulus(3, 1'b1);
        tick();
        tick();
        applyStimulus(4, 1'b1);
        tick();
        tick();
        applyStimulus(5, 1'b0);
        checkOutput("drop_overflow_early", 32'(overflow), 32'd1);
        waitIdle(600);
        checkOutput("drop_count", 32'(wrCount), 32'd256);
        checkOutput("drop_overflow", 32'(overflow), 32'd1);
        checkOutput("drop_spurious", 32'(spurious), 32'd0);

        // Vector arriving in the cycle the first vector's last word is on mem_we.
        doStart();
        applyStimulus(6, 1'b1);
        k = lastIvCyc;
        tick();
        applyStimulus(7, 1'b1);
        while (cyc < k + 128) tick();
        applyStimulus(8, 1'b1);
        waitIdle(800);
        checkOutput("edge_count", 32'(wrCount), 32'd384);
        checkOutput("edge_span", 32'(lastCyc - firstCyc), 32'd383);
        checkOutput("edge_overflow", 32'(overflow), 32'd0);
        checkOutput("edge_spurious", 32'(spurious), 32'd0);

        // Whole image, then in_valid in DONE must be ignored.
        doStart();
        doneSeen = 1'b0;
        for (int p = 0; p < N_PIX; p++) begin
            applyStimulus(p + 10, 1'b1);
            repeat (288) tick();
        end
        waitIdle(400);
        checkOutput("image_count", 32'(wrCount), 32'(N_PIX * DSP_NO));
        checkOutput("image_last_addr", 32'(lastAddrSeen), 32'(LAST_ADDR));
        checkOutput("image_done_next", 32'(doneSeen), 32'd1);
        applyStimulus(50, 1'b0);
        repeat (300) tick();
        checkOutput("image_done_hold", 32'(done), 32'd1);
        checkOutput("image_busy", 32'(busy), 32'd0);
        checkOutput("image_spurious", 32'(spurious), 32'd0);
        checkOutput("image_overflow", 32'(overflow), 32'd0);

        // Asynchronous reset in the middle of a drain, then a clean restart.
        doStart();
        applyStimulus(60, 1'b1);
        k = lastIvCyc;
        monEn = 1'b0;
        sbQ.delete();
        while (cyc < k + 51) tick();
        checkOutput("mid_we", 32'(mem_we), 32'd1);
        checkOutput("mid_addr", 32'(mem_addr), 32'(CH_BASE + 50));
        rst = 1'b0;
        #1;
        checkResetOutputs("midrst");
        tick();
        tick();
        rst = 1'b1;
        tick();
        monEn = 1'b1;
        doStart();
        applyStimulus(61, 1'b1);
        k = lastIvCyc;
        waitIdle(400);
        checkOutput("restart_count", 32'(wrCount), 32'd128);
        checkOutput("restart_first_cyc", 32'(firstCyc), 32'(k + 1));
        checkOutput("restart_spurious", 32'(spurious), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/fire5_ex_3_wb.md
FIRE5_EX_3_WB -- requirements
Module: fire5_ex_3_wb

Interface
REQ-001 SHALL have parameter DSP_NO, default 128, meaning vector length (output channels per expand-3x3 result).
REQ-002 SHALL have parameter WIDTH, default 16, meaning activation word width.
REQ-003 SHALL have parameter N_PIX, default 1024, meaning output pixels per image (32*32).
REQ-004 SHALL have parameter CH_TOTAL, default 256, meaning channels of the concatenated fire5 output.
REQ-005 SHALL have parameter CH_BASE, default 128, meaning channel offset of the expand-3x3 half.
REQ-006 SHALL have port clk, input, 1, meaning clock.
REQ-007 SHALL have port rst, input, 1, meaning reset; asynchronous, active-low.
REQ-008 SHALL have port start, input, 1, meaning one-cycle pulse that begins a new image.
REQ-009 SHALL have port in_valid, input, 1, meaning one-cycle pulse when vec_in holds a new ReLU'd vector.
REQ-010 SHALL have port vec_in, input, DSP_NO x WIDTH, meaning parallel expand-3x3 outputs, channel i at index i.
REQ-011 SHALL have port mem_we, output, 1, meaning write strobe to the fire5 output RAM.
REQ-012 SHALL have port mem_addr, output, clog2(N_PIX*CH_TOTAL) (18), meaning word address.
REQ-013 SHALL have port mem_wdata, output, WIDTH, meaning write data.
REQ-014 SHALL have port busy, output, 1, meaning at least one captured vector not yet fully written.
REQ-015 SHALL have port done, output, 1, meaning all N_PIX vectors written; sticky until start or reset.
REQ-016 SHALL have port overflow, output, 1, meaning a vector was dropped; sticky until start or reset.

Function
REQ-017 SHALL hold a two-bank vector buffer; each bank holds one DSP_NO-word vector plus a full flag.
REQ-018 SHALL, on in_valid with a free bank, capture vec_in into the free bank (bank 0 preferred when both free) in that cycle.
REQ-019 SHALL treat a bank as free in the same cycle its last word (channel DSP_NO-1) is written, so in_valid coinciding with that write is accepted.
REQ-020 SHALL, on in_valid with both banks full and neither finishing, drop the vector, set overflow, and leave pixel count unchanged.
REQ-021 SHALL drain banks in capture order, one word per cycle, channel 0 first; mem_we high for exactly DSP_NO consecutive cycles per vector when the next bank is already full.
REQ-022 SHALL issue the first write (channel 0) in the cycle after capture when idle (latency 1); the last write follows DSP_NO-1 cycles later.
REQ-023 SHALL compute mem_addr = pix*CH_TOTAL + CH_BASE + ch, pix being the 0-based count of vectors drained, ch the channel index.
REQ-024 SHALL register mem_we, mem_addr, mem_wdata; mem_addr and mem_wdata are don't-care when mem_we is low.
REQ-025 SHALL implement FSM IDLE -> DRAIN (a bank full) -> IDLE (no bank full after last word) or DRAIN (other bank full, no gap cycle); DRAIN -> DONE after the last word of vector pix = N_PIX-1.
REQ-026 SHALL, in DONE, hold done high, ignore in_valid, and return to IDLE only on start.
REQ-027 SHALL, on start in any state, clear both full flags, pixel and channel counters, done and overflow, abort any drain and go to IDLE; an in_valid in the same cycle as start is ignored.
REQ-028 SHALL drive busy = any bank full.

Reset
REQ-029 SHALL, on rst low, asynchronously force IDLE, full flags 0, counters 0, mem_we 0, mem_addr 0, mem_wdata 0, busy 0, done 0, overflow 0.
REQ-030 SHALL leave buffer data storage unreset (no functional dependence on it).

Structure
REQ-031 SHALL place DSP_NO, WIDTH, N_PIX, CH_TOTAL, CH_BASE defaults, the address width, and the FSM state enum (IDLE, DRAIN, DONE) in shared package fire5_pkg.
REQ-032 SHALL implement the two-bank storage with full flags and bank select as sub-module vec_pingpong; FSM and address generation stay in fire5_ex_3_wb.

Verification
REQ-033 SHALL cover: reset, start, one in_valid with vec_in[i]=i+1 -> writes addr 128..255 data 1..128 in cycles t+1..t+128, then busy 0.
REQ-034 SHALL cover: two in_valid 2 cycles apart -> 256 contiguous mem_we cycles, second vector at addr 384..511, overflow 0.
REQ-035 SHALL cover: three in_valid within 10 cycles -> third dropped, overflow 1, only addr 128..511 written.
REQ-036 SHALL cover: in_valid exactly on last-word cycle with other bank full -> accepted, overflow 0.
REQ-037 SHALL cover: 1024 vectors spaced 289 cycles -> last write addr 262143, done 1 next cycle, later in_valid produces no write.
REQ-038 SHALL cover: rst low mid-drain at channel 50 -> mem_we 0 immediately, all outputs at reset values; start then in_valid restarts at addr 128.
